pass_ctrl_fsm: RTL

Parametrised control FSM for the password-keeper datapath. It replaces the fixed 16-entry controller. At boot it loads the CAM from flash. Per request it either retrieves a stored password (CAM hit: decrypt, then re-encrypt under the local master key) or stores a new one (CAM miss: encrypt, write flash and CAM). It adds depth parametrisation, a delete mode, a full flag, enc/dec timeouts with an error exit, and fully registered outputs.

---
 rtl/pass_ctrl_fsm.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pass_ctrl_fsm.sv
// Password-keeper control FSM: boot-time CAM load, then per-request fetch, store or delete.
// All outputs are registered, decoded from the next state.
//
// state          | meaning
// ---------------+-------------------------------------------------------------
// BOOT           | compare load pointer with entry count
// LOAD_CAM       | copy one flash entry into the CAM
// BUSY_CAM       | advance load pointer
// BOOT_DONE      | boot finished, raise boot_done_signal
// IDLE           | wait for go
// GO             | select account path for the CAM search
// SEARCH         | cam_start, wait CAM_LAT cycles for match
// MATCHED        | hit: load stored password
// DEC_START      | start decrypt
// DEC_WAIT       | wait dec_done (timeout guarded)
// ENC_MASTER     | start re-encrypt under local master key
// ENC_WAIT       | wait enc_done (timeout guarded)
// NEW_LOAD       | miss: load new plaintext and master key
// ENC_START      | start encrypt of new password
// ENC_STORE_WAIT | wait enc_done (timeout guarded)
// STORE          | write flash and CAM at address count
// INC            | bump entry count
// DELETE         | clear CAM entry at match_addr
// OUT            | done pulse, error flag, out_reg load
module pass_ctrl_fsm #(
  parameter int ADDR_W  = 4,
  parameter int CAM_LAT = 1,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              del,
  input  logic [ADDR_W:0]   stored_cnt,
  input  logic              match,
  input  logic [ADDR_W-1:0] match_addr,
  input  logic              enc_done,
  input  logic              dec_done,
  output logic [ADDR_W-1:0] address_out,
  output logic              cam_start,
  output logic              cam_write_en,
  output logic              cam_clear_en,
  output logic              flash_write_en,
  output logic              start_enc,
  output logic              start_dec,
  output logic              boot_load_reg,
  output logic              pass_enc_reg,
  output logic              plain_reg,
  output logic              out_reg,
  output logic              flash_or_acc_sel,
  output logic              flash_or_acc_reg,
  output logic              flash_acc_reg,
  output logic              flash_pass_reg,
  output logic              new_old_pass_sel,
  output logic              local_master_sel,
  output logic              local_master_reg,
  output logic              boot_done_signal,
  output logic              done,
  output logic              error,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TO_W-1:0] TO_LAST   = '1 - 1'b1;
  localparam logic [2:0]      CAM_LAT_C = 3'(CAM_LAT);

  typedef enum logic [4:0] {
    S_BOOT, S_LOAD_CAM, S_BUSY_CAM, S_BOOT_DONE, S_IDLE, S_GO, S_SEARCH,
    S_MATCHED, S_DEC_START, S_DEC_WAIT, S_ENC_MASTER, S_ENC_WAIT,
    S_NEW_LOAD, S_ENC_START, S_ENC_STORE_WAIT, S_STORE, S_INC, S_DELETE, S_OUT
  } state_t;

  state_t              state, nxt;
  logic [ADDR_W:0]     ptr, n_reg, n_in, n_cur, cnt_d;
  logic                boot_first, del_q, err_d;
  logic [2:0]          cam_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic                in_wait, to_last;

  logic [ADDR_W-1:0]   addr_d;
  logic cam_start_d, cam_write_en_d, cam_clear_en_d, flash_write_en_d;
  logic start_enc_d, start_dec_d, boot_load_reg_d, pass_enc_reg_d;
  logic plain_reg_d, out_reg_d, flash_or_acc_sel_d, flash_or_acc_reg_d;
  logic flash_acc_reg_d, flash_pass_reg_d, new_old_pass_sel_d;
  logic local_master_sel_d, local_master_reg_d, done_d, error_d;

  assign n_in    = (stored_cnt > DEPTH_C) ? DEPTH_C : stored_cnt;
  assign n_cur   = boot_first ? n_in : n_reg;
  assign in_wait = (state == S_DEC_WAIT) || (state == S_ENC_WAIT) ||
                   (state == S_ENC_STORE_WAIT);
  // the counter reaches its limit on the edge that leaves the wait state
  assign to_last = (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_BOOT;
      ptr              <= '0;
      n_reg            <= '0;
      boot_first       <= 1'b1;
      del_q            <= 1'b0;
      cam_cnt          <= '0;
      to_cnt           <= '0;
      count            <= '0;
      full             <= 1'b0;
      boot_done_signal <= 1'b0;
      address_out      <= '0;
      cam_start        <= 1'b0;
      cam_write_en     <= 1'b0;
      cam_clear_en     <= 1'b0;
      flash_write_en   <= 1'b0;
      start_enc        <= 1'b0;
      start_dec        <= 1'b0;
      boot_load_reg    <= 1'b0;
      pass_enc_reg     <= 1'b0;
      plain_reg        <= 1'b0;
      out_reg          <= 1'b0;
      flash_or_acc_sel <= 1'b0;
      flash_or_acc_reg <= 1'b0;
      flash_acc_reg    <= 1'b0;
      flash_pass_reg   <= 1'b0;
      new_old_pass_sel <= 1'b0;
      local_master_sel <= 1'b0;
      local_master_reg <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_BOOT && boot_first) begin
        n_reg      <= n_in;
        boot_first <= 1'b0;
      end
      if (state == S_BUSY_CAM) ptr <= ptr + 1'b1;
      if (state == S_IDLE && go) del_q <= del;
      cam_cnt <= (state == S_SEARCH && nxt == S_SEARCH) ? cam_cnt + 3'd1 : 3'd0;
      to_cnt  <= (in_wait && nxt == state) ? to_cnt + 1'b1 : '0;
      count   <= cnt_d;
      full    <= (cnt_d == DEPTH_C);
      if (state == S_BOOT_DONE) boot_done_signal <= 1'b1;
      address_out      <= addr_d;
      cam_start        <= cam_start_d;
      cam_write_en     <= cam_write_en_d;
      cam_clear_en     <= cam_clear_en_d;
      flash_write_en   <= flash_write_en_d;
      start_enc        <= start_enc_d;
      start_dec        <= start_dec_d;
      boot_load_reg    <= boot_load_reg_d;
      pass_enc_reg     <= pass_enc_reg_d;
      plain_reg        <= plain_reg_d;
      out_reg          <= out_reg_d;
      flash_or_acc_sel <= flash_or_acc_sel_d;
      flash_or_acc_reg <= flash_or_acc_reg_d;
      flash_acc_reg    <= flash_acc_reg_d;
      flash_pass_reg   <= flash_pass_reg_d;
      new_old_pass_sel <= new_old_pass_sel_d;
      local_master_sel <= local_master_sel_d;
      local_master_reg <= local_master_reg_d;
      done             <= done_d;
      error            <= error_d;
    end
  end

  always_comb begin
    nxt   = state;
    err_d = 1'b0;
    cnt_d = count;
    case (state)
      S_BOOT: begin
        if (ptr < n_cur) begin
          nxt = S_LOAD_CAM;
        end else begin
          nxt   = S_BOOT_DONE;
          cnt_d = n_cur;
        end
      end
      S_LOAD_CAM:   nxt = S_BUSY_CAM;
      S_BUSY_CAM:   nxt = S_BOOT;
      S_BOOT_DONE:  nxt = S_IDLE;
      S_IDLE:       if (go) nxt = S_GO;
      S_GO:         nxt = S_SEARCH;
      S_SEARCH: begin
        if (cam_cnt == CAM_LAT_C) begin
          if (del_q) begin
            if (match) nxt = S_DELETE;
            else begin
              nxt   = S_OUT;
              err_d = 1'b1;
            end
          end else if (match) begin
            nxt = S_MATCHED;
          end else if (full) begin
            nxt   = S_OUT;
            err_d = 1'b1;
          end else begin
            nxt = S_NEW_LOAD;
          end
        end
      end
      S_MATCHED:    nxt = S_DEC_START;
      S_DEC_START:  nxt = S_DEC_WAIT;
      S_DEC_WAIT: begin
        if (dec_done) nxt = S_ENC_MASTER;
        else if (to_last) begin
          nxt   = S_OUT;
          err_d = 1'b1;
        end
      end
      S_ENC_MASTER: nxt = S_ENC_WAIT;
      S_ENC_WAIT: begin
        if (enc_done) nxt = S_OUT;
        else if (to_last) begin
          nxt   = S_OUT;
          err_d = 1'b1;
        end
      end
      S_NEW_LOAD:   nxt = S_ENC_START;
      S_ENC_START:  nxt = S_ENC_STORE_WAIT;
      S_ENC_STORE_WAIT: begin
        if (enc_done) nxt = S_STORE;
        else if (to_last) begin
          nxt   = S_OUT;
          err_d = 1'b1;
        end
      end
      S_STORE:      nxt = S_INC;
      S_INC: begin
        nxt = S_OUT;
        if (count < DEPTH_C) cnt_d = count + 1'b1;
      end
      S_DELETE:     nxt = S_OUT;
      S_OUT:        nxt = S_IDLE;
      default:      nxt = S_BOOT;
    endcase
  end

  always_comb begin
    addr_d             = address_out;
    cam_start_d        = 1'b0;
    cam_write_en_d     = 1'b0;
    cam_clear_en_d     = 1'b0;
    flash_write_en_d   = 1'b0;
    start_enc_d        = 1'b0;
    start_dec_d        = 1'b0;
    boot_load_reg_d    = 1'b0;
    pass_enc_reg_d     = 1'b0;
    plain_reg_d        = 1'b0;
    out_reg_d          = 1'b0;
    flash_or_acc_sel_d = 1'b0;
    flash_or_acc_reg_d = 1'b0;
    flash_acc_reg_d    = 1'b0;
    flash_pass_reg_d   = 1'b0;
    new_old_pass_sel_d = 1'b0;
    local_master_sel_d = 1'b0;
    local_master_reg_d = 1'b0;
    done_d             = 1'b0;
    error_d            = 1'b0;
    case (nxt)
      S_LOAD_CAM: begin
        cam_write_en_d     = 1'b1;
        flash_or_acc_reg_d = 1'b1;
        addr_d             = ptr[ADDR_W-1:0];
      end
      S_GO: begin
        flash_or_acc_sel_d = 1'b1;
        flash_or_acc_reg_d = 1'b1;
      end
      S_SEARCH:     cam_start_d = (state != S_SEARCH);
      S_MATCHED: begin
        boot_load_reg_d = 1'b1;
        pass_enc_reg_d  = 1'b1;
        addr_d          = match_addr;
      end
      S_DEC_START: begin
        start_dec_d        = 1'b1;
        new_old_pass_sel_d = 1'b1;
      end
      S_DEC_WAIT: begin
        new_old_pass_sel_d = 1'b1;
        plain_reg_d        = 1'b1;
      end
      S_ENC_MASTER: begin
        start_enc_d        = 1'b1;
        local_master_sel_d = 1'b1;
        local_master_reg_d = 1'b1;
      end
      S_NEW_LOAD: begin
        plain_reg_d        = 1'b1;
        local_master_reg_d = 1'b1;
      end
      S_ENC_START:  start_enc_d = 1'b1;
      S_ENC_STORE_WAIT: begin
        flash_acc_reg_d  = 1'b1;
        flash_pass_reg_d = 1'b1;
      end
      S_STORE: begin
        flash_write_en_d   = 1'b1;
        cam_write_en_d     = 1'b1;
        flash_or_acc_reg_d = 1'b1;
        addr_d             = count[ADDR_W-1:0];
      end
      S_DELETE: begin
        cam_clear_en_d = 1'b1;
        addr_d         = match_addr;
      end
      S_OUT: begin
        out_reg_d = 1'b1;
        done_d    = 1'b1;
        error_d   = err_d;
      end
      default: ;
    endcase
  end

endmodule
